// File: rtl/sram_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM state encoding,
// external SRAM geometry and the default base address of the data window.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          SRAM_AW       = 18;
  localparam int          SRAM_DW       = 16;
  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_ctrl.sv
// MEM-stage data-memory controller: splits a 32-bit load/store into two 16-bit SRAM accesses.
// Optional SRAM_LAST_READ_BUF_EN adds a one-entry buffer that serves repeated loads without freezing.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int            CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WLAST = CW'(WAIT_CYCLES - 1);

  state_t               state;
  logic [CW-1:0]        wcnt;
  logic                 op_wr;
  logic [16:0]          word_q;
  logic [SRAM_DW-1:0]   wdata_hi;
  logic                 dq_oe;
  logic [SRAM_DW-1:0]   dq_out;
  logic [16:0]          word;
  logic                 hit;
  logic                 req;
  logic                 half_last;
  logic [31:0]          buf_data;

  // Word index wraps modulo 128K words; address[1:0] drop out of the shift.
  assign word      = 17'((address - BASE_ADDR) >> 2);
  assign req       = wr_en | (rd_en & ~hit);
  assign ready     = ((state == IDLE) & ~req) | (state == DONE);
  assign half_last = (wcnt == WLAST);

  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DW{1'bz}};
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

`ifdef SRAM_LAST_READ_BUF_EN
  logic        buf_vld;
  logic [16:0] buf_word;

  assign hit = rd_en & ~wr_en & buf_vld & (buf_word == word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld  <= 1'b0;
      buf_word <= '0;
      buf_data <= '0;
    end else if ((state == HI) && half_last && !op_wr) begin
      buf_vld  <= 1'b1;
      buf_word <= word_q;
      buf_data <= {SRAM_DQ, read_data[15:0]};
    end else if ((state == IDLE) && wr_en && buf_vld && (buf_word == word)) begin
      // Keep the buffered copy coherent with a store to the same word.
      buf_data <= write_data;
    end
  end
`else
  assign hit      = 1'b0;
  assign buf_data = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      op_wr     <= 1'b0;
      word_q    <= '0;
      wdata_hi  <= '0;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr     <= wr_en;
            word_q    <= word;
            wdata_hi  <= write_data[31:16];
            wcnt      <= '0;
            state     <= LO;
            SRAM_ADDR <= {word, 1'b0};
            SRAM_WE_N <= ~wr_en;
            dq_oe     <= wr_en;
            dq_out    <= write_data[15:0];
          end else if (hit) begin
            read_data <= buf_data;
          end
        end
        LO: begin
          if (half_last) begin
            wcnt      <= '0;
            state     <= HI;
            SRAM_ADDR <= {word_q, 1'b1};
            dq_out    <= wdata_hi;
            if (!op_wr) read_data[15:0] <= SRAM_DQ;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        HI: begin
          if (half_last) begin
            wcnt      <= '0;
            state     <= DONE;
            SRAM_WE_N <= 1'b1;
            dq_oe     <= 1'b0;
            if (!op_wr) read_data[31:16] <= SRAM_DQ;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized self-checking bench for sram_ctrl with a behavioural async SRAM (W=2).
// Honours SRAM_LAST_READ_BUF_EN in its reference model when the build defines it.
module tb_sram_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] SRAM_DQ;
  wire  [17:0] SRAM_ADDR;
  wire         SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

  sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_UB_N  (SRAM_UB_N),
    .SRAM_LB_N  (SRAM_LB_N),
    .SRAM_CE_N  (SRAM_CE_N),
    .SRAM_OE_N  (SRAM_OE_N)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM: drives the bus whenever not being written.
  logic [15:0] sram_mem [0:262143];
  assign SRAM_DQ = SRAM_WE_N ? sram_mem[SRAM_ADDR] : 16'bz;
  always @(negedge clk) if (!SRAM_WE_N) sram_mem[SRAM_ADDR] <= SRAM_DQ;

  // Reference: what the memory should contain, plus last-read-buffer state.
  logic [15:0] ref_mem [0:262143];
  bit          rbuf_vld;
  logic [16:0] rbuf_w;
  bit          last_full;
  int          n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    return 17'(((a - 32'd1024) / 32'd4) % 32'd131072);
  endfunction

  task automatic idle(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    last_full = 1'b0;
  endtask

  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [16:0] w, output int cyc);
    logic hb;
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    if (last_full) begin @(posedge clk); #1; end
    else #1;
    cyc = 0;
    while (!ready && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (!ready) begin
        hb = (cyc > W);
        chk("sram_we_n", 32'(SRAM_WE_N), 32'(!wr));
        chk("sram_addr", 32'(SRAM_ADDR), 32'({w, hb}));
        if (!wr) chk("dq_read", 32'(SRAM_DQ), 32'(sram_mem[SRAM_ADDR]));
      end
    end
    if (cyc == 0) begin
      @(posedge clk); #1;
      last_full = 1'b0;
    end else begin
      last_full = 1'b1;
    end
  endtask

  task automatic do_op(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    logic [16:0] w;
    logic [17:0] lo_i, hi_i;
    logic [31:0] exp_rd;
    int          cyc, exp_cyc;
    w       = word_of(a);
    lo_i    = {w, 1'b0};
    hi_i    = {w, 1'b1};
    exp_rd  = {ref_mem[hi_i], ref_mem[lo_i]};
    exp_cyc = 2 * W + 1;
`ifdef SRAM_LAST_READ_BUF_EN
    if (!wr && rbuf_vld && rbuf_w == w) exp_cyc = 0;
`endif
    access(wr, rd, a, d, w, cyc);
    chk("freeze_cycles", 32'(cyc), 32'(exp_cyc));
    if (wr) begin
      ref_mem[lo_i] = d[15:0];
      ref_mem[hi_i] = d[31:16];
    end else begin
      chk("read_data", read_data, exp_rd);
      rbuf_vld = 1'b1;
      rbuf_w   = w;
    end
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    for (int i = 0; i < 262144; i++) begin
      sram_mem[i] = 16'h0000;
      ref_mem[i]  = 16'h0000;
    end
    n_vec = 0; n_err = 0;
    rbuf_vld = 1'b0; rbuf_w = '0; last_full = 1'b0;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("tied_ctl", 32'({SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Store then load the same word.
    do_op(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    idle(1);
    chk("sram2", 32'(sram_mem[2]), 32'h0000BEEF);
    chk("sram3", 32'(sram_mem[3]), 32'h0000DEAD);
    do_op(1'b0, 1'b1, 32'd1028, 32'h0);
    chk("done_ready", 32'(ready), 32'd1);
    idle(1);

    // Back-to-back load then store with requests held through the freeze.
    do_op(1'b0, 1'b1, 32'd1036, 32'h0);
    do_op(1'b1, 1'b0, 32'd1036, 32'h12345678);
    idle(1);
    do_op(1'b0, 1'b1, 32'd1036, 32'h0);
    idle(1);

    // Address wrap to half-words 0/1; rd&wr together counts as a store.
    do_op(1'b1, 1'b1, 32'd1024 + 32'd4 * 32'd131072, 32'hCAFEF00D);
    idle(1);
    chk("wrap_sram0", 32'(sram_mem[0]), 32'h0000F00D);
    chk("wrap_sram1", 32'(sram_mem[1]), 32'h0000CAFE);
    do_op(1'b0, 1'b1, 32'd1024, 32'h0);
    idle(1);

    // Repeated load, store to the same word, reload.
    do_op(1'b0, 1'b1, 32'd1028, 32'h0);
    do_op(1'b0, 1'b1, 32'd1028, 32'h0);
    idle(1);
    do_op(1'b1, 1'b0, 32'd1028, 32'h55AA33CC);
    idle(1);
    do_op(1'b0, 1'b1, 32'd1028, 32'h0);
    idle(1);

    // Reset in the middle of the HI half of a store.
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; write_data = 32'h11112222;
    repeat (3) begin @(posedge clk); #1; end
    chk("hi_we_n", 32'(SRAM_WE_N), 32'd0);
    chk("hi_addr", 32'(SRAM_ADDR), 32'd9);
    rst_n = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("abort_addr", 32'(SRAM_ADDR), 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    ref_mem[8] = 16'h2222;
    rbuf_vld   = 1'b0;
    rst_n      = 1'b1;
    idle(1);
    do_op(1'b0, 1'b1, 32'd1028, 32'h0);
    do_op(1'b0, 1'b1, 32'd1040, 32'h0);
    idle(1);

    // Randomized traffic over a small aliased window.
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      a  = 32'd1024 + 32'd4 * 32'($urandom_range(0, 7))
         + (($urandom_range(0, 1) != 0) ? 32'd4 * 32'd131072 : 32'd0)
         + 32'($urandom_range(0, 3));
      case (op)
        0, 1: do_op(1'b0, 1'b1, a, 32'h0);
        2:    do_op(1'b1, 1'b0, a, $urandom);
        default: do_op(1'b1, 1'b1, a, $urandom);
      endcase
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
